// File: rtl/note_sequencer_if.sv
// Control, pattern-write and oscillator-drive bundle for note_sequencer.
// SEQ_TRANSPOSE_EN adds the transpose input.
interface note_sequencer_if;
  logic       start;
  logic       stop;
  logic       loop;
  logic [3:0] len;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [2:0] wr_data;
`ifdef SEQ_TRANSPOSE_EN
  logic [1:0] transpose;
`endif
  logic       en;
  logic [1:0] note_sel;
  logic       busy;
  logic [3:0] step_idx;
  logic       done;

  modport master (
    output start, stop, loop, len, wr_en, wr_addr, wr_data,
`ifdef SEQ_TRANSPOSE_EN
    transpose,
`endif
    input  en, note_sel, busy, step_idx, done
  );

  modport slave (
    input  start, stop, loop, len, wr_en, wr_addr, wr_data,
`ifdef SEQ_TRANSPOSE_EN
    transpose,
`endif
    output en, note_sel, busy, step_idx, done
  );
endinterface

// File: rtl/note_sequencer.sv
// 16-step note/rest pattern player driving an oscillator's enable and note select.
// Optional SEQ_TRANSPOSE_EN adds a per-step transpose of the note code.
module note_sequencer #(
  parameter int STEP_CYCLES = 6_250_000,
  parameter int GAP_CYCLES  = 625_000
) (
  input logic              clk,
  input logic              rst_n,
  note_sequencer_if.slave  bus
);
  localparam int CW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] NOTE_LAST = CW'(STEP_CYCLES - GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    idx, idx_d, len_q, len_d, ld_addr;
  logic          en_q, en_d, busy_q, busy_d, done_q, done_d, ld;
  logic [1:0]    note_q, note_d;
  logic [2:0]    pat [16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) pat[i] <= 3'b000;
    end else if (bus.wr_en) begin
      pat[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      len_q  <= '0;
      en_q   <= 1'b0;
      note_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      len_q  <= len_d;
      en_q   <= en_d;
      note_q <= note_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    len_d   = len_q;
    en_d    = en_q;
    note_d  = note_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ld      = 1'b0;
    ld_addr = 4'd0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = NOTE;
          cnt_d   = '0;
          idx_d   = 4'd0;
          len_d   = bus.len;
          busy_d  = 1'b1;
          ld      = 1'b1;
        end
      end
      NOTE, GAP: begin
        if (bus.stop) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = 4'd0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt == STEP_LAST) begin
          // step end is checked first so a zero gap never visits GAP
          cnt_d = '0;
          if (idx < len_q) begin
            state_d = NOTE;
            idx_d   = idx + 4'd1;
            ld      = 1'b1;
            ld_addr = idx + 4'd1;
          end else if (bus.loop) begin
            state_d = NOTE;
            idx_d   = 4'd0;
            ld      = 1'b1;
          end else begin
            state_d = IDLE;
            idx_d   = 4'd0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
          if (state == NOTE && cnt == NOTE_LAST) begin
            state_d = GAP;
            en_d    = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (ld) begin
      en_d = ~pat[ld_addr][2];
`ifdef SEQ_TRANSPOSE_EN
      note_d = pat[ld_addr][1:0] + bus.transpose;
`else
      note_d = pat[ld_addr][1:0];
`endif
    end
  end

  assign bus.en       = en_q;
  assign bus.note_sel = note_q;
  assign bus.busy     = busy_q;
  assign bus.step_idx = idx;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: expected output changes (with cycle spacing)
// are queued by the stimulus and checked by monitors whenever the outputs change.
module tb_note_sequencer;
  typedef struct {
    int         dt;
    logic [8:0] v;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  note_sequencer_if b ();
  note_sequencer_if b0 ();

  note_sequencer #(.STEP_CYCLES(10), .GAP_CYCLES(2)) u_dut (.clk(clk), .rst_n(rst_n), .bus(b));
  note_sequencer #(.STEP_CYCLES(4), .GAP_CYCLES(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

  exp_t       q[$], q0[$];
  int         n_cmp = 0, n_bad = 0;
  int         cyc = 0, ref_cyc = 0, ref_cyc0 = 0;
  logic [8:0] prev = '0, prev0 = '0, cur, cur0;
  exp_t       e, e0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input exp_t x, input logic [8:0] got, input int dt);
    n_cmp++;
    if (got !== x.v || (x.dt >= 0 && dt != x.dt)) begin
      n_bad++;
      $display("FAIL %s: got out=%b dt=%0d, required out=%b dt=%0d", x.tag, got, dt, x.v, x.dt);
    end
  endfunction

  function automatic void unexpected(input string who, input logic [8:0] got);
    n_cmp++;
    n_bad++;
    $display("FAIL %s_unexpected_change: got out=%b, required no change", who, got);
  endfunction

  // {en, note_sel, busy, step_idx, done}
  always @(negedge clk) begin
    cur = {b.en, b.note_sel, b.busy, b.step_idx, b.done};
    if (cur !== prev) begin
      if (q.size() == 0) unexpected("dut", cur);
      else begin
        e = q.pop_front();
        chk(e, cur, cyc - ref_cyc);
      end
      ref_cyc = cyc;
    end
    prev = cur;
  end

  always @(negedge clk) begin
    cur0 = {b0.en, b0.note_sel, b0.busy, b0.step_idx, b0.done};
    if (cur0 !== prev0) begin
      if (q0.size() == 0) unexpected("dut0", cur0);
      else begin
        e0 = q0.pop_front();
        chk(e0, cur0, cyc - ref_cyc0);
      end
      ref_cyc0 = cyc;
    end
    prev0 = cur0;
  end

  task automatic push(input bit s, input int dt, input logic en, input logic [1:0] note,
                      input logic busy, input logic [3:0] idx, input logic done, input string tag);
    exp_t x;
    x.dt  = dt;
    x.v   = {en, note, busy, idx, done};
    x.tag = tag;
    if (s) q0.push_back(x);
    else q.push_back(x);
  endtask

  // One 10-cycle step of the main DUT: onset after first_dt, gap 8 cycles later unless rest.
  task automatic step_ev(input int first_dt, input logic [1:0] note, input logic [3:0] idx, input bit rest);
    push(0, first_dt, !rest, note, 1'b1, idx, 1'b0, $sformatf("step%0d_onset", idx));
    if (!rest) push(0, 8, 1'b0, note, 1'b1, idx, 1'b0, $sformatf("step%0d_gap", idx));
  endtask

  task automatic done_ev(input bit s, input int dt, input logic [1:0] note);
    push(s, dt, 1'b0, note, 1'b0, 4'd0, 1'b1, "done_pulse");
    push(s, 1, 1'b0, note, 1'b0, 4'd0, 1'b0, "done_clear");
  endtask

  task automatic wr(input bit s, input logic [3:0] addr, input logic [2:0] data);
    @(negedge clk); #1;
    if (s) begin b0.wr_en = 1'b1; b0.wr_addr = addr; b0.wr_data = data; end
    else begin b.wr_en = 1'b1; b.wr_addr = addr; b.wr_data = data; end
    @(posedge clk); #1;
    b.wr_en = 1'b0;
    b0.wr_en = 1'b0;
  endtask

  task automatic go_start(input bit s);
    @(negedge clk); #1;
    if (s) begin b0.start = 1'b1; ref_cyc0 = cyc; end
    else begin b.start = 1'b1; ref_cyc = cyc; end
    @(posedge clk); #1;
    b.start = 1'b0;
    b0.start = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q.size() != 0 || q0.size() != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0 || q0.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d/%0d events pending, required 0", q.size(), q0.size());
      q.delete();
      q0.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic seq_0123();
    step_ev(1, 2'd0, 4'd0, 0);
    step_ev(2, 2'd1, 4'd1, 0);
    step_ev(2, 2'd2, 4'd2, 0);
    step_ev(2, 2'd3, 4'd3, 0);
    done_ev(0, 2, 2'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000ns, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    {b.start, b.stop, b.loop, b.wr_en} = '0;
    {b0.start, b0.stop, b0.loop, b0.wr_en} = '0;
    b.len = '0; b.wr_addr = '0; b.wr_data = '0;
    b0.len = '0; b0.wr_addr = '0; b0.wr_data = '0;
`ifdef SEQ_TRANSPOSE_EN
    b.transpose = 2'd0;
    b0.transpose = 2'd0;
`endif
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // one-shot 4-step pattern
    for (int i = 0; i < 4; i++) wr(0, 4'(i), 3'(i));
    b.len = 4'd3;
    seq_0123();
    go_start(0);
    drain();

    // rest on step 1
    wr(0, 4'd1, 3'b110);
    step_ev(1, 2'd0, 4'd0, 0);
    step_ev(2, 2'd2, 4'd1, 1);
    step_ev(10, 2'd2, 4'd2, 0);
    step_ev(2, 2'd3, 4'd3, 0);
    done_ev(0, 2, 2'd3);
    go_start(0);
    drain();

    // loop LEN=1, then clear LOOP during the third pass of step 1
    wr(0, 4'd1, 3'b001);
    b.len = 4'd1;
    b.loop = 1'b1;
    for (int i = 0; i < 6; i++) step_ev(i == 0 ? 1 : 2, 2'(i % 2), 4'(i % 2), 0);
    done_ev(0, 2, 2'd1);
    go_start(0);
    repeat (54) @(posedge clk);
    #1 b.loop = 1'b0;
    drain();

    // STOP at counter 5 of step 2
    b.len = 4'd3;
    step_ev(1, 2'd0, 4'd0, 0);
    step_ev(2, 2'd1, 4'd1, 0);
    push(0, 2, 1'b1, 2'd2, 1'b1, 4'd2, 1'b0, "step2_onset");
    push(0, 6, 1'b0, 2'd2, 1'b0, 4'd0, 1'b0, "stop_abort");
    go_start(0);
    repeat (25) @(posedge clk);
    #1 b.stop = 1'b1;
    @(posedge clk); #1 b.stop = 1'b0;
    drain();

    // START with STOP in IDLE: no output change expected
    @(negedge clk); #1 {b.start, b.stop} = 2'b11;
    @(posedge clk); #1 {b.start, b.stop} = 2'b00;
    repeat (6) @(negedge clk);

    // START while busy is ignored
    seq_0123();
    go_start(0);
    repeat (14) @(posedge clk);
    #1 b.start = 1'b1;
    @(posedge clk); #1 b.start = 1'b0;
    drain();

    // async reset mid-NOTE clears outputs and pattern
    wr(0, 4'd0, 3'b011);
    b.len = 4'd0;
    b.loop = 1'b1;
    push(0, 1, 1'b1, 2'd3, 1'b1, 4'd0, 1'b0, "pre_reset_onset");
    push(0, 3, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, "async_reset");
    go_start(0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    drain();
    @(negedge clk); #1 rst_n = 1'b1;
    b.loop = 1'b0;
    repeat (2) @(negedge clk);
    step_ev(1, 2'd0, 4'd0, 0);
    done_ev(0, 2, 2'd0);
    go_start(0);
    drain();

    // zero gap: EN stays high across consecutive steps
    wr(1, 4'd0, 3'b001);
    wr(1, 4'd1, 3'b010);
    b0.len = 4'd1;
    push(1, 1, 1'b1, 2'd1, 1'b1, 4'd0, 1'b0, "gap0_step0");
    push(1, 4, 1'b1, 2'd2, 1'b1, 4'd1, 1'b0, "gap0_step1");
    done_ev(1, 4, 2'd2);
    go_start(1);
    drain();

`ifdef SEQ_TRANSPOSE_EN
    wr(1, 4'd0, 3'b011);
    b0.len = 4'd0;
    b0.transpose = 2'd2;
    push(1, 1, 1'b1, 2'd1, 1'b1, 4'd0, 1'b0, "transpose_note");
    done_ev(1, 4, 2'd1);
    go_start(1);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
